bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: bus cycles allowed before a transaction is aborted.
REQ-002 Parameter FAIR_N, default 4: consecutive data grants allowed while a fetch is waiting.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 if_req  in  1  fetch request, held until if_ack.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  fetch data, valid with if_ack.
REQ-008 if_ack  out  1  one-cycle fetch completion.
REQ-009 mem_req, mem_we  in  1  data request, held until mem_ack; write enable.
REQ-010 mem_size  in  2  access size: 00 byte, 01 half, 10 word.
REQ-011 mem_addr, mem_wdata  in  32  byte address; store data, right-justified.
REQ-012 mem_rdata  out  32  raw bus word for the MEM-stage aligner; mem_sel  out  4  byte lanes used.
REQ-013 mem_ack  out  1  one-cycle data completion; mem_adel, mem_ades  out  1  load/store address error, valid with mem_ack.
REQ-014 bus_req, bus_we  out  1; bus_addr  out  32; bus_sel  out  4; bus_wdata  out  32  single-port memory request.
REQ-015 bus_rdata  in  32; bus_ack  in  1  memory completion.
REQ-016 bus_err  out  1  one-cycle pulse on timeout abort.
REQ-017 stall_o  out  1  pipeline hold.

Function
REQ-018 FSM states: IDLE, FETCH, DATA, ERRACK. Exactly one bus transaction is outstanding at a time.
REQ-019 IDLE, mem_req=1, misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to ERRACK, no bus_req; next cycle mem_ack=1 and adel=~mem_we, ades=mem_we.
REQ-020 IDLE, aligned mem_req and if_req: grant DATA, unless the fair counter equals FAIR_N, in which case grant FETCH.
REQ-021 The fair counter increments on each DATA grant while if_req=1, saturates at FAIR_N, and clears on a FETCH grant or when if_req=0.
REQ-022 Once granted, bus_req, bus_addr={addr[31:2],2'b00}, bus_sel, bus_we, bus_wdata are registered and held stable until bus_ack.
REQ-023 Lane mapping is big-endian. Byte: addr[1:0] 00->1000, 01->0100, 10->0010, 11->0001. Half: addr[1] 0->1100, 1->0011. Word: 1111. Fetch: 1111, read-only.
REQ-024 Store data is replicated across lanes: byte as {4{wdata[7:0]}}, half as {2{wdata[15:0]}}, word unchanged.
REQ-025 On the bus_ack cycle the FSM returns to IDLE; in the next cycle the granted port's ack=1 and rdata=captured bus_rdata. The earliest new grant is the cycle after the ack.
REQ-026 mem_sel reflects the lanes of the completed data access when mem_ack=1.
REQ-027 Timeout counter clears at each grant and increments while waiting. At TIMEOUT it drops bus_req, pulses bus_err, returns to IDLE, and acks the port with rdata=0 and no address-error flags.
REQ-028 bus_ack while in IDLE or ERRACK is ignored.
REQ-029 stall_o = (if_req & ~if_ack) | (mem_req & ~mem_ack), combinational.
REQ-030 A request dropped mid-transaction does not abort the bus cycle; the ack is still issued once.

Reset
REQ-031 With rst=0 at a clock edge: FSM=IDLE, fair and timeout counters=0, all outputs except stall_o=0. This applies mid-transaction, with bus_req dropped the next cycle.

Structure
REQ-032 The shared package holds the FSM state enum, mem_size encodings and the TIMEOUT/FAIR_N defaults.
REQ-033 Lane-select and store-replication logic forms one combinational sub-module, bus_lane_gen.

Verification
REQ-034 Byte load mem_addr=0x1003, bus_rdata=0xAABBCCDD, ack after 2 cycles -> bus_addr=0x1000, bus_sel=0001, mem_rdata=0xAABBCCDD, one mem_ack.
REQ-035 Half store mem_addr=0x2002, wdata=0x1234 -> bus_sel=0011, bus_wdata=0x12341234, bus_we=1.
REQ-036 Word load at 0x3001 -> no bus_req, mem_ack with mem_adel=1; word store at 0x3002 -> mem_ades=1.
REQ-037 if_req and mem_req held continuously, 1-cycle bus_ack -> data granted 4 times, then 1 fetch, repeating.
REQ-038 bus_ack never asserted -> bus_err after 255 waiting cycles, ack with rdata=0, FSM back in IDLE.
REQ-039 rst=0 during DATA wait -> next cycle bus_req=0, no ack issued, stall_o tracks pending requests.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the instruction/data bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DATA   = 2'd2,
    ST_ERRACK = 2'd3
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int FAIR_N_DEFAULT  = 4;

endpackage

// File: rtl/bus_lane_gen.sv
// Big-endian byte-lane select, store-data replication and alignment check
// for a data-port access.
module bus_lane_gen
  import bus_arbiter_pkg::*;
(
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  always_comb begin
    sel        = 4'b1111;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (mem_size)
      SIZE_BYTE: begin
        sel       = 4'b1000 >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      // the unused 2'b11 encoding is handled like a word access
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory bus,
// with fetch-starvation protection and a bus timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no transaction outstanding; grant decision made here
// ST_FETCH  | fetch request on the bus, waiting for bus_ack / timeout
// ST_DATA   | data request on the bus, waiting for bus_ack / timeout
// ST_ERRACK | misaligned data access being acked with an address error
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int FAIR_N  = FAIR_N_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic [3:0]  mem_sel,
  output logic        mem_ack,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        stall_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FAIR_N + 1);

  arb_state_e    state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [FW-1:0] fair_cnt;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_wdata;
  logic          misaligned;
  logic          ack_if_q, ack_mem_q, err_we_q, bus_err_q;
  logic [31:0]   rdata_q;
  logic [3:0]    mem_sel_q;
  logic          grant_data, grant_fetch, go_err, bus_done, tmo_hit;

  bus_lane_gen u_lane_gen (
    .mem_size   (mem_size),
    .addr_lo    (mem_addr[1:0]),
    .wdata      (mem_wdata),
    .sel        (lane_sel),
    .wdata_rep  (lane_wdata),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // No grant while a port ack is showing: the requester still holds its
  // request during that cycle and would otherwise be served twice.
  always_comb begin
    state_nxt   = state;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    go_err      = 1'b0;
    bus_done    = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!(ack_if_q || ack_mem_q)) begin
          if (mem_req && misaligned) begin
            state_nxt = ST_ERRACK;
            go_err    = 1'b1;
          end else if (mem_req && !(if_req && fair_cnt == FW'(FAIR_N))) begin
            state_nxt  = ST_DATA;
            grant_data = 1'b1;
          end else if (if_req) begin
            state_nxt   = ST_FETCH;
            grant_fetch = 1'b1;
          end
        end
      end
      ST_FETCH, ST_DATA: begin
        if (bus_ack) begin
          state_nxt = ST_IDLE;
          bus_done  = 1'b1;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = ST_IDLE;
          tmo_hit   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    if_ack    = ack_if_q;
    mem_ack   = ack_mem_q | (state == ST_ERRACK);
    mem_adel  = (state == ST_ERRACK) & ~err_we_q;
    mem_ades  = (state == ST_ERRACK) & err_we_q;
    if_rdata  = rdata_q;
    mem_rdata = rdata_q;
    mem_sel   = mem_sel_q;
    bus_err   = bus_err_q;
  end

  assign stall_o = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      tmo_cnt   <= '0;
      fair_cnt  <= '0;
      ack_if_q  <= 1'b0;
      ack_mem_q <= 1'b0;
      err_we_q  <= 1'b0;
      bus_err_q <= 1'b0;
      rdata_q   <= '0;
      mem_sel_q <= '0;
    end else begin
      ack_if_q  <= 1'b0;
      ack_mem_q <= 1'b0;
      bus_err_q <= 1'b0;
      mem_sel_q <= '0;

      if (grant_data) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_we;
        bus_addr  <= mem_addr & 32'hFFFF_FFFC;
        bus_sel   <= lane_sel;
        bus_wdata <= lane_wdata;
        tmo_cnt   <= '0;
      end else if (grant_fetch) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b0;
        bus_addr  <= if_addr & 32'hFFFF_FFFC;
        bus_sel   <= 4'b1111;
        bus_wdata <= '0;
        tmo_cnt   <= '0;
      end else if ((state == ST_FETCH || state == ST_DATA) && !bus_ack) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (bus_done || tmo_hit) begin
        bus_req   <= 1'b0;
        bus_we    <= 1'b0;
        rdata_q   <= bus_done ? bus_rdata : 32'h0;
        ack_if_q  <= (state == ST_FETCH);
        ack_mem_q <= (state == ST_DATA);
        mem_sel_q <= (state == ST_DATA) ? bus_sel : 4'b0000;
        bus_err_q <= tmo_hit;
      end

      if (go_err) begin
        err_we_q <= mem_we;
        rdata_q  <= '0;
      end

      if (!if_req || grant_fetch)
        fair_cnt <= '0;
      else if (grant_data && fair_cnt != FW'(FAIR_N))
        fair_cnt <= fair_cnt + FW'(1);
    end
  end

endmodule
